// File: rtl/vga_pkg.sv
// Shared VGA geometry constants, RGB332 pixel type and sprite palette.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t PALETTE [0:7] = '{
    8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'hFF, 8'h92
  };
endpackage

// File: rtl/bounce_axis.sv
// One motion axis: position walks by STEP per enabled frame and reflects at 0 / LIMIT.
module bounce_axis #(
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  output logic [9:0] pos,
  output logic       bounce
);
  logic        dir;            // 0 = increasing, 1 = decreasing
  logic        hit;
  logic [10:0] pos_w;
  logic [10:0] lim_w;
  logic [10:0] step_w;

  assign pos_w  = {1'b0, pos};
  assign lim_w  = 11'(LIMIT);
  assign step_w = 11'(STEP);

  // Would the next step reach or cross the wall in the current direction
  always_comb begin
    hit = 1'b0;
    if (dir) hit = (pos_w <= step_w);
    else     hit = (pos_w + step_w >= lim_w);
  end

  assign bounce = step_en & hit;

  // Advance or reflect once per frame update; LIMIT==0 just toggles dir at 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (step_en) begin
      if (hit) begin
        pos <= dir ? 10'd0 : lim_w[9:0];
        dir <= ~dir;
      end else begin
        pos <= dir ? (pos - step_w[9:0]) : (pos + step_w[9:0]);
      end
    end
  end
endmodule

// File: rtl/vga_bounce_sprite.sv
// Bouncing solid sprite pixel source; registered RGB332 out with one-pixel lookahead.
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int          SPRITE_W = 32,
  parameter int          SPRITE_H = 32,
  parameter int          STEP     = 2,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic       vgaclk,
  input  logic       rst,
  input  logic [9:0] hc_in,
  input  logic [9:0] vc_in,
  input  logic       enable,
  output logic [2:0] out_red,
  output logic [2:0] out_green,
  output logic [1:0] out_blue,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);
  localparam int MIN_WH = (SPRITE_W < SPRITE_H) ? SPRITE_W : SPRITE_H;

  if (SPRITE_W > H_ACTIVE || SPRITE_H > V_ACTIVE || STEP == 0 || STEP > MIN_WH) begin : g_bad_param
    $error("vga_bounce_sprite: illegal SPRITE_W/SPRITE_H/STEP combination");
  end

  logic [9:0]  hn, vn;
  logic        cnt_ok, active, in_sprite, frame_evt, step_en;
  logic        bounce_x, bounce_y;
  logic [9:0]  x, y;
  logic [2:0]  pal_idx;
  rgb332_t     pix_q;

  // Successor pixel, so the registered colour lands on the pixel being shown
  always_comb begin
    hn = hc_in + 10'd1;
    vn = vc_in;
    if (hc_in == 10'(H_TOTAL - 1)) begin
      hn = '0;
      vn = (vc_in == 10'(V_TOTAL - 1)) ? 10'd0 : vc_in + 10'd1;
    end
  end

  // Out-of-range counters must never render, even if the successor wraps into range
  assign cnt_ok    = (hc_in < 10'(H_TOTAL)) && (vc_in < 10'(V_TOTAL));
  assign active    = cnt_ok && (hn < 10'(H_ACTIVE)) && (vn < 10'(V_ACTIVE));
  assign in_sprite = ({1'b0, hn} >= {1'b0, x}) && ({1'b0, hn} < {1'b0, x} + 11'(SPRITE_W)) &&
                     ({1'b0, vn} >= {1'b0, y}) && ({1'b0, vn} < {1'b0, y} + 11'(SPRITE_H));

  // Last pixel of last active line: motion is applied entirely inside blanking
  assign frame_evt = (hc_in == 10'(H_TOTAL - 1)) && (vc_in == 10'(V_ACTIVE - 1));
  assign step_en   = frame_evt & enable;

  bounce_axis #(.LIMIT(H_ACTIVE - SPRITE_W), .STEP(STEP)) u_x (
    .clk(vgaclk), .rst(rst), .step_en(step_en), .pos(x), .bounce(bounce_x)
  );

  bounce_axis #(.LIMIT(V_ACTIVE - SPRITE_H), .STEP(STEP)) u_y (
    .clk(vgaclk), .rst(rst), .step_en(step_en), .pos(y), .bounce(bounce_y)
  );

  // Frame pulse plus one palette step / bounce count per frame, even on a corner hit
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      frame_tick   <= 1'b0;
      pal_idx      <= '0;
      bounce_count <= '0;
    end else begin
      frame_tick <= frame_evt;
      if (bounce_x | bounce_y) begin
        pal_idx      <= pal_idx + 3'd1;
        bounce_count <= bounce_count + 8'd1;
      end
    end
  end

  // Pixel output register: sprite colour, background, or black in blanking
  always_ff @(posedge vgaclk) begin
    if (!rst)                       pix_q <= '0;
    else if (active && in_sprite)   pix_q <= PALETTE[pal_idx];
    else if (active)                pix_q <= BG_COLOR;
    else                            pix_q <= '0;
  end

  assign out_red   = pix_q.r;
  assign out_green = pix_q.g;
  assign out_blue  = pix_q.b;
endmodule

// File: tb/tb_vga_bounce_sprite.sv
// Directed bench for vga_bounce_sprite: default-size DUT plus a 192-wide corner-hit DUT.
module tb_vga_bounce_sprite;
  logic       vgaclk = 1'b0;
  logic       rst;
  logic [9:0] hc_in, vc_in;
  logic       enable;
  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;
  logic       tick0, tick1;
  logic [7:0] bc0, bc1;
  int         vecs = 0;
  int         errs = 0;
  int         ticks;

  always #5 vgaclk = ~vgaclk;

  vga_bounce_sprite dut (
    .vgaclk(vgaclk), .rst(rst), .hc_in(hc_in), .vc_in(vc_in), .enable(enable),
    .out_red(r0), .out_green(g0), .out_blue(b0), .frame_tick(tick0), .bounce_count(bc0)
  );

  vga_bounce_sprite #(.SPRITE_W(192), .SPRITE_H(32)) u_corner (
    .vgaclk(vgaclk), .rst(rst), .hc_in(hc_in), .vc_in(vc_in), .enable(enable),
    .out_red(r1), .out_green(g1), .out_blue(b1), .frame_tick(tick1), .bounce_count(bc1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Drive counters, take one edge, settle past it
  task automatic cyc(input int hc, input int vc);
    hc_in = 10'(hc);
    vc_in = 10'(vc);
    @(posedge vgaclk);
    #1;
  endtask

  // One frame event followed by one ordinary cycle
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(799, 479);
      if (tick0) ticks++;
      cyc(0, 0);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; hc_in = '0; vc_in = '0; ticks = 0;
    // 1: reset with arbitrary counters
    cyc($urandom_range(0, 799), $urandom_range(0, 524));
    cyc($urandom_range(0, 799), $urandom_range(0, 524));
    chk("rst_out",  {r0, g0, b0}, 8'h00);
    chk("rst_tick", tick0, 0);
    chk("rst_bc",   bc0, 0);
    chk("rst_x",    dut.x, 0);
    chk("rst_y",    dut.y, 0);
    rst = 1'b1;

    // 2: lookahead alignment at sprite (0,0)
    cyc(30, 0);   chk("al_in",    {r0, g0, b0}, 8'hE0);
    cyc(31, 0);   chk("al_edge",  {r0, g0, b0}, 8'h00);
    cyc(799, 0);  chk("al_wrap",  {r0, g0, b0}, 8'hE0);
    cyc(639, 0);  chk("al_blank", {r0, g0, b0}, 8'h00);
    cyc(1023, 0); chk("al_oor",   {r0, g0, b0}, 8'h00);

    // 3: first frame event
    cyc(799, 479);
    chk("f1_tick", tick0, 1);
    chk("f1_x", dut.x, 2);
    chk("f1_y", dut.y, 2);
    cyc(798, 479);
    chk("f1_notick", tick0, 0);

    // 4/5: run to frame 224 (Y wall; corner for the wide sprite)
    frames(223);
    chk("f224_y",    dut.y, 448);
    chk("f224_x",    dut.x, 448);
    chk("f224_diry", dut.u_y.dir, 1);
    chk("f224_pal",  dut.pal_idx, 1);
    chk("f224_bc",   bc0, 1);
    cyc(447, 448);
    chk("f224_pix",  {r0, g0, b0}, 8'h1C);
    chk("cn_x",    u_corner.x, 448);
    chk("cn_y",    u_corner.y, 448);
    chk("cn_dirx", u_corner.u_x.dir, 1);
    chk("cn_diry", u_corner.u_y.dir, 1);
    chk("cn_bc",   bc1, 1);
    chk("cn_pal",  u_corner.pal_idx, 1);

    frames(1);
    chk("f225_y", dut.y, 446);
    frames(79);
    chk("f304_x",  dut.x, 608);
    chk("f304_y",  dut.y, 288);
    chk("f304_bc", bc0, 2);

    // 6: frozen motion, rendering continues
    enable = 1'b0;
    ticks = 0;
    frames(10);
    chk("dis_ticks", ticks, 10);
    chk("dis_x",  dut.x, 608);
    chk("dis_y",  dut.y, 288);
    chk("dis_bc", bc0, 2);
    cyc(607, 288);
    chk("dis_pix", {r0, g0, b0}, 8'h03);

    // mid-line reset aborts everything
    cyc(607, 288);
    rst = 1'b0;
    cyc(799, 479);
    chk("mr_out",  {r0, g0, b0}, 8'h00);
    chk("mr_tick", tick0, 0);
    chk("mr_bc",   bc0, 0);
    chk("mr_x",    dut.x, 0);
    chk("mr_y",    dut.y, 0);
    chk("mr_pal",  dut.pal_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
